dac_frame_scheduler: RTL and testbench

- Sequences the 2-channel PCM DAC datapath in the slot_clk domain.
- Pulls bytes from the audio RX FIFO's read side, assembles left/right samples into a double buffer, and swaps the buffer at frame boundaries.
- Drives the serial port pins pbck/plrck/pdata.
- Replaces hardcoded ratio/resolution handling with configurable settings, proper zero-latency valid/ready reads, and underrun detection/muting.

---
 rtl/dac_frame_scheduler_pkg.sv | 19 +
 rtl/dac_frame_scheduler_if.sv | 11 +
 rtl/dac_frame_scheduler_pcm_serializer.sv | 56 +++++
 rtl/dac_frame_scheduler.sv | 167 ++++++++++++++++
 tb/tb_dac_frame_scheduler.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_frame_scheduler_pkg.sv
// Shared FSM encoding, frame byte counts and sample resolutions for the DAC frame scheduler.
package dac_frame_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int BYTES_24 = 6;
  localparam int BYTES_16 = 4;
  localparam int RES_24   = 24;
  localparam int RES_16   = 16;

  function automatic logic [2:0] last_byte_idx(input logic res24);
    return res24 ? 3'(BYTES_24 - 1) : 3'(BYTES_16 - 1);
  endfunction

endpackage

// File: rtl/dac_frame_scheduler_if.sv
// Read side of the audio RX FIFO (first-word-fall-through): byte moves when valid && ready.
interface dac_frame_scheduler_if;

  logic       fifo_rd_valid;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_ready;

  modport master (output fifo_rd_valid, output fifo_rd_data, input fifo_rd_ready);
  modport slave  (input fifo_rd_valid, input fifo_rd_data, output fifo_rd_ready);

endinterface

// File: rtl/dac_frame_scheduler_pcm_serializer.sv
// Turns the frame counter and the current stereo sample into registered pbck/plrck/pdata pins.
module dac_frame_scheduler_pcm_serializer
  import dac_frame_scheduler_pkg::*;
#(
  parameter int RATIO   = 256,
  parameter int BCK_DIV = 4,
  parameter int CNT_W   = 10
) (
  input  logic             slot_clk,
  input  logic             reset,
  input  logic             active,
  input  logic             res24,
  input  logic [CNT_W-1:0] cnt,
  input  logic [23:0]      cur_l,
  input  logic [23:0]      cur_r,
  output logic             pbck,
  output logic             plrck,
  output logic             pdata,
  output logic             out_en
);

  localparam int               BCK_LOG = $clog2(BCK_DIV);
  localparam logic [CNT_W-1:0] HALF    = CNT_W'(RATIO / 2);

  logic             in_left;
  logic [CNT_W-1:0] slot;
  logic [CNT_W-1:0] res_bits;
  logic [23:0]      sample;
  logic [4:0]       bit_idx;
  logic             bit_val;

  // Left-justified MSB-first: slot s carries sample bit 23-s, slots past the resolution are 0.
  always_comb begin
    in_left  = cnt < HALF;
    slot     = (cnt & (HALF - 1'b1)) >> BCK_LOG;
    res_bits = res24 ? CNT_W'(RES_24) : CNT_W'(RES_16);
    sample   = in_left ? cur_l : cur_r;
    bit_idx  = 5'd23 - slot[4:0];
    bit_val  = (slot < res_bits) ? sample[bit_idx] : 1'b0;
  end

  always_ff @(posedge slot_clk) begin
    if (reset || !active) begin
      pbck   <= 1'b0;
      plrck  <= 1'b0;
      pdata  <= 1'b0;
      out_en <= 1'b0;
    end else begin
      pbck   <= cnt[BCK_LOG-1];
      plrck  <= in_left;
      pdata  <= bit_val;
      out_en <= 1'b1;
    end
  end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Fills a double-buffered stereo sample from the RX FIFO and swaps it in at every frame wrap,
// muting and counting underruns when the fill is incomplete.
module dac_frame_scheduler
  import dac_frame_scheduler_pkg::*;
#(
  parameter int RATIO   = 256,
  parameter int BCK_DIV = 4,
  parameter int CNT_W   = 10,
  parameter int UR_W    = 16
) (
  input  logic                 slot_clk,
  input  logic                 reset,
  input  logic                 cfg_enable,
  input  logic                 cfg_res24,
  dac_frame_scheduler_if.slave rd,
  output logic                 pbck,
  output logic                 plrck,
  output logic                 pdata,
  output logic                 out_en,
  output logic                 frame_start,
  output logic                 underrun,
  output logic [UR_W-1:0]      underrun_count
);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        byte_idx, byte_idx_n, split;
  logic [23:0]       nxt_l, nxt_r, nxt_l_n, nxt_r_n;
  logic [23:0]       cur_l, cur_r, cur_l_n, cur_r_n;
  logic [23:0]       byte_word, byte_mask, fill_l, fill_r;
  logic [1:0]        pos;
  logic [UR_W-1:0]   count_n;
  logic              res24, res24_n, ur_n, wrap, xfer, last, to_right;

  assign wrap             = (cnt == CNT_W'(RATIO - 1));
  assign rd.fifo_rd_ready = (state == FILL);
  assign xfer             = rd.fifo_rd_valid && (state == FILL);
  assign last             = (byte_idx == last_byte_idx(res24));

  // Byte slot -> channel and byte lane; 16-bit frames never touch the low lane.
  always_comb begin
    split     = res24 ? 3'd3 : 3'd2;
    to_right  = byte_idx >= split;
    pos       = to_right ? 2'(byte_idx - split) : 2'(byte_idx);
    byte_word = {rd.fifo_rd_data, 16'h0000} >> {pos, 3'b000};
    byte_mask = 24'hFF0000 >> {pos, 3'b000};
    fill_l    = to_right ? nxt_l : ((nxt_l & ~byte_mask) | byte_word);
    fill_r    = to_right ? ((nxt_r & ~byte_mask) | byte_word) : nxt_r;
  end

  // A disable at the wrap wins over everything; a final byte landing on the wrap edge counts as full.
  always_comb begin
    state_n    = state;
    byte_idx_n = byte_idx;
    nxt_l_n    = nxt_l;
    nxt_r_n    = nxt_r;
    cur_l_n    = cur_l;
    cur_r_n    = cur_r;
    res24_n    = res24;
    ur_n       = 1'b0;
    count_n    = underrun_count;
    unique case (state)
      IDLE: begin
        if (wrap && cfg_enable) begin
          state_n    = FILL;
          res24_n    = cfg_res24;
          byte_idx_n = '0;
          nxt_l_n    = '0;
          nxt_r_n    = '0;
        end
      end
      FILL: begin
        if (wrap && !cfg_enable) begin
          state_n    = IDLE;
          byte_idx_n = '0;
          nxt_l_n    = '0;
          nxt_r_n    = '0;
          cur_l_n    = '0;
          cur_r_n    = '0;
        end else begin
          if (xfer) begin
            nxt_l_n    = fill_l;
            nxt_r_n    = fill_r;
            byte_idx_n = last ? 3'd0 : byte_idx + 3'd1;
          end
          if (wrap) begin
            if (xfer && last) begin
              cur_l_n = fill_l;
              cur_r_n = fill_r;
            end else begin
              cur_l_n = '0;
              cur_r_n = '0;
              ur_n    = 1'b1;
              if (underrun_count != '1) count_n = underrun_count + 1'b1;
            end
          end else if (xfer && last) begin
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (wrap) begin
          if (!cfg_enable) begin
            state_n    = IDLE;
            byte_idx_n = '0;
            nxt_l_n    = '0;
            nxt_r_n    = '0;
            cur_l_n    = '0;
            cur_r_n    = '0;
          end else begin
            state_n = FILL;
            cur_l_n = nxt_l;
            cur_r_n = nxt_r;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge slot_clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      byte_idx       <= '0;
      nxt_l          <= '0;
      nxt_r          <= '0;
      cur_l          <= '0;
      cur_r          <= '0;
      res24          <= 1'b1;
      underrun_count <= '0;
      frame_start    <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= wrap ? '0 : cnt + 1'b1;
      byte_idx       <= byte_idx_n;
      nxt_l          <= nxt_l_n;
      nxt_r          <= nxt_r_n;
      cur_l          <= cur_l_n;
      cur_r          <= cur_r_n;
      res24          <= res24_n;
      underrun_count <= count_n;
      frame_start    <= wrap;
      underrun       <= ur_n;
    end
  end

  dac_frame_scheduler_pcm_serializer #(
    .RATIO  (RATIO),
    .BCK_DIV(BCK_DIV),
    .CNT_W  (CNT_W)
  ) u_serializer (
    .slot_clk(slot_clk),
    .reset   (reset),
    .active  (state != IDLE),
    .res24   (res24),
    .cnt     (cnt),
    .cur_l   (cur_l),
    .cur_r   (cur_r),
    .pbck    (pbck),
    .plrck   (plrck),
    .pdata   (pdata),
    .out_en  (out_en)
  );

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Randomized directed bench: a frame-level queue model predicts every pin, pulse and count each cycle.
module tb_dac_frame_scheduler;
  import dac_frame_scheduler_pkg::*;

  localparam int RATIO   = 256;
  localparam int BCK_DIV = 4;
  localparam int CNT_W   = 10;
  localparam int UR_W    = 16;
  localparam int HALF    = RATIO / 2;

  logic            slot_clk = 1'b0;
  logic            reset = 1'b1;
  logic            cfg_enable = 1'b0;
  logic            cfg_res24 = 1'b1;
  logic            pbck, plrck, pdata, out_en, frame_start, underrun;
  logic [UR_W-1:0] underrun_count;

  dac_frame_scheduler_if fifo ();

  dac_frame_scheduler #(
    .RATIO(RATIO), .BCK_DIV(BCK_DIV), .CNT_W(CNT_W), .UR_W(UR_W)
  ) dut (
    .slot_clk      (slot_clk),
    .reset         (reset),
    .cfg_enable    (cfg_enable),
    .cfg_res24     (cfg_res24),
    .rd            (fifo),
    .pbck          (pbck),
    .plrck         (plrck),
    .pdata         (pdata),
    .out_en        (out_en),
    .frame_start   (frame_start),
    .underrun      (underrun),
    .underrun_count(underrun_count)
  );

  always #5 slot_clk = ~slot_clk;

  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          wraps = 0;
  int          gate_pct = 100;
  bit          hold_last = 1'b0;
  logic [7:0]  src[$];
  logic [31:0] cap_l, cap_r;

  // Reference model: playing flag, accepted-but-unplayed bytes, the sample on air, underrun tally.
  int          m_cnt, m_count;
  bit          m_en, m_res;
  logic [7:0]  m_pend[$];
  logic [23:0] m_cur_l, m_cur_r;

  task automatic modelReset();
    m_cnt = 0; m_count = 0; m_en = 1'b0; m_res = 1'b1;
    m_pend.delete(); m_cur_l = '0; m_cur_r = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    int          nb, pre_cnt, slot, res_bits;
    bit          pre_en, ready_m, acc, wrap_m, ur_m;
    logic [23:0] smp;
    logic [7:0]  dbyte;
    logic [6:0]  obs, expv;
    @(negedge slot_clk);
    nb = m_res ? BYTES_24 : BYTES_16;
    ready_m = m_en && (m_pend.size() < nb);
    fifo.fifo_rd_valid = 1'b0;
    fifo.fifo_rd_data  = 8'($urandom);
    if (src.size() > 0 && $urandom_range(99) < gate_pct
        && !(hold_last && m_pend.size() == nb - 1 && m_cnt != RATIO - 1)) begin
      fifo.fifo_rd_valid = 1'b1;
      fifo.fifo_rd_data  = src[0];
    end
    acc = fifo.fifo_rd_valid && ready_m;
    dbyte = 8'h00;
    if (acc) dbyte = src.pop_front();
    pre_en = m_en;
    pre_cnt = m_cnt;
    slot = (pre_cnt % HALF) / BCK_DIV;
    res_bits = m_res ? 24 : 16;
    smp = (pre_cnt < HALF) ? m_cur_l : m_cur_r;
    expv = '0;
    if (pre_en) begin
      expv[6] = 1'b1;
      expv[5] = (pre_cnt % BCK_DIV) >= (BCK_DIV / 2);
      expv[4] = pre_cnt < HALF;
      if (slot < res_bits) expv[3] = smp[23 - slot];
    end
    wrap_m = (pre_cnt == RATIO - 1);
    ur_m = 1'b0;
    @(posedge slot_clk);
    cyc++;
    if (reset) begin
      modelReset();
      expv = '0;
    end else begin
      if (acc) m_pend.push_back(dbyte);
      if (wrap_m) begin
        if (!m_en) begin
          if (cfg_enable) begin
            m_en = 1'b1; m_res = cfg_res24; m_pend.delete();
          end
        end else if (!cfg_enable) begin
          m_en = 1'b0; m_pend.delete(); m_cur_l = '0; m_cur_r = '0;
        end else if (m_pend.size() == nb) begin
          if (m_res) begin
            m_cur_l = {m_pend[0], m_pend[1], m_pend[2]};
            m_cur_r = {m_pend[3], m_pend[4], m_pend[5]};
          end else begin
            m_cur_l = {m_pend[0], m_pend[1], 8'h00};
            m_cur_r = {m_pend[2], m_pend[3], 8'h00};
          end
          m_pend.delete();
        end else begin
          m_cur_l = '0; m_cur_r = '0; ur_m = 1'b1;
          if (m_count < 2 ** UR_W - 1) m_count++;
        end
        wraps++;
      end
      m_cnt = (m_cnt + 1) % RATIO;
      expv[2] = wrap_m;
      expv[1] = ur_m;
    end
    expv[0] = m_en && (m_pend.size() < (m_res ? BYTES_24 : BYTES_16));
    #1;
    if (!reset && pre_en && (pre_cnt % BCK_DIV) == 0) begin
      if (pre_cnt < HALF) cap_l = {cap_l[30:0], pdata};
      else                cap_r = {cap_r[30:0], pdata};
    end
    obs = {out_en, pbck, plrck, pdata, frame_start, underrun, fifo.fifo_rd_ready};
    checkOutput("pins", 32'(obs), 32'(expv));
    checkOutput("underrun_count", 32'(underrun_count), 32'(m_count));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic runWraps(input int n);
    int target;
    target = wraps + n;
    for (int i = 0; i < (n + 1) * RATIO && wraps < target; i++) applyStimulus();
  endtask

  task automatic pushBytes(input logic [47:0] bytes, input int count);
    for (int i = count - 1; i >= 0; i--) src.push_back(bytes[i*8 +: 8]);
  endtask

  task automatic pushRandom(input int count);
    for (int i = 0; i < count; i++) src.push_back(8'($urandom));
  endtask

  initial begin
    fifo.fifo_rd_valid = 1'b0;
    fifo.fifo_rd_data  = 8'h00;
    cap_l = '0;
    cap_r = '0;
    modelReset();

    // Reset state.
    reset = 1'b1; runCycles(3);
    reset = 1'b0; runCycles(2);
    checkOutput("reset_count", 32'(underrun_count), 32'd0);

    // 24-bit frame 12 34 56 / AB CD EF, next buffer kept full behind it.
    cfg_enable = 1'b1; cfg_res24 = 1'b1;
    pushBytes(48'h123456ABCDEF, 6); pushRandom(6);
    runWraps(3);
    checkOutput("word24_left", cap_l, 32'h12345600);
    checkOutput("word24_right", cap_r, 32'hABCDEF00);
    checkOutput("word24_count", 32'(underrun_count), 32'd0);

    // 16-bit frame 80 01 / 7F FE.
    reset = 1'b1; src.delete(); runCycles(1);
    reset = 1'b0; cfg_res24 = 1'b0;
    pushBytes(48'h80017FFE, 4); pushRandom(4);
    runWraps(3);
    checkOutput("word16_left", cap_l, 32'h80010000);
    checkOutput("word16_right", cap_r, 32'h7FFE0000);

    // Starved FIFO, then a frame split across an underrun.
    reset = 1'b1; src.delete(); runCycles(1);
    reset = 1'b0; cfg_res24 = 1'b1;
    runWraps(4);
    checkOutput("starve_count", 32'(underrun_count), 32'd3);
    pushBytes(48'h1122, 2);
    runWraps(1);
    checkOutput("partial_count", 32'(underrun_count), 32'd4);
    pushBytes(48'h33445566, 4);
    runWraps(1);

    // Final byte accepted exactly on the wrap edge.
    hold_last = 1'b1;
    pushBytes(48'h9ABCDE13579B, 6);
    runWraps(1);
    hold_last = 1'b0;
    checkOutput("split_left", cap_l, 32'h11223300);
    checkOutput("split_right", cap_r, 32'h44556600);
    checkOutput("edge_count", 32'(underrun_count), 32'd4);
    pushRandom(6);
    runWraps(1);
    checkOutput("edge_left", cap_l, 32'h9ABCDE00);
    checkOutput("edge_right", cap_r, 32'h13579B00);

    // Disable mid-fill after 3 bytes, then re-enable.
    pushBytes(48'h010203, 3);
    runCycles(10);
    cfg_enable = 1'b0;
    runWraps(1);
    runCycles(2);
    checkOutput("disable_out_en", 32'(out_en), 32'd0);
    checkOutput("disable_ready", 32'(fifo.fifo_rd_ready), 32'd0);
    checkOutput("disable_count", 32'(underrun_count), 32'd4);
    cfg_enable = 1'b1;
    pushBytes(48'hAABBCC010203, 6); pushRandom(6);
    runWraps(3);
    checkOutput("realign_left", cap_l, 32'hAABBCC00);
    checkOutput("realign_right", cap_r, 32'h01020300);

    // Reset mid-frame while playing, then stay disabled.
    runCycles(100);
    reset = 1'b1; cfg_enable = 1'b0; runCycles(1);
    checkOutput("midreset_count", 32'(underrun_count), 32'd0);
    checkOutput("midreset_pins", 32'({out_en, pbck, plrck, pdata, underrun}), 32'd0);
    reset = 1'b0;
    runCycles(2 * RATIO);
    checkOutput("idle_ready", 32'(fifo.fifo_rd_ready), 32'd0);

    // Random soak: configuration changes, bursty FIFO, random frame lengths.
    for (int f = 0; f < 12; f++) begin
      cfg_enable = ($urandom_range(5) != 0);
      cfg_res24  = 1'($urandom_range(1));
      gate_pct   = $urandom_range(100, 30);
      pushRandom($urandom_range(9));
      runCycles($urandom_range(RATIO, RATIO / 2));
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
